// File: rtl/lc3_mem_pkg.sv
// Shared encodings for the LC3 memory access unit: opcodes, FSM states and
// condition-code layout, plus the N/Z/P derivation used on load completion.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        OP_LD  = 2'b00,
        OP_ST  = 2'b01,
        OP_LDI = 2'b10,
        OP_STI = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ACC1 = 2'b01,
        S_ACC2 = 2'b10,
        S_FIN  = 2'b11
    } state_e;

    localparam int CC_N_BIT = 2;
    localparam int CC_Z_BIT = 1;
    localparam int CC_P_BIT = 0;

    localparam logic [2:0] CC_Z = 3'b010;

    // Exactly one of N/Z/P is set for any 16-bit value.
    function automatic logic [2:0] cc_of(input logic [15:0] value);
        logic [2:0] flags;
        flags = '0;
        if (value[15])
            flags[CC_N_BIT] = 1'b1;
        else if (value == '0)
            flags[CC_Z_BIT] = 1'b1;
        else
            flags[CC_P_BIT] = 1'b1;
        return flags;
    endfunction

    // LDI and STI fetch a pointer in the first access and use it in the second.
    function automatic logic is_indirect(input op_e op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Ready-handshaked memory port between the access unit (master) and the
// unified instruction/data memory (slave).
interface mem_access_unit_if;

    logic        en;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;

    modport master (
        output en,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ready
    );

    modport slave (
        input  en,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ready
    );

endinterface

// File: rtl/mem_access_unit_wait_timer.sv
// Per-access wait counter: counts cycles spent waiting for the memory and
// flags the cycle in which the wait limit would be reached without READY.
module mem_wait_timer #(
    parameter int WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] LAST = (WAIT_MAX == 0) ? '0 : CW'(WAIT_MAX - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (tick && !expired)
            count <= count + CW'(1);
    end

    // The final waiting cycle is the one whose miss would push the count to
    // WAIT_MAX; a READY in that same cycle still wins because tick is low.
    assign expired = (WAIT_MAX != 0) && tick && (count == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// LC3 memory access unit: turns an effective address into one (LD/ST) or two
// (LDI/STI) handshaked memory accesses and returns load data with N/Z/P codes.
module mem_access_unit
    import lc3_mem_pkg::*;
#(
    parameter int         WAIT_MAX = 16,
    parameter logic [2:0] CC_RESET = CC_Z
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req,
    input  logic [1:0]                op,
    input  logic [15:0]               ea,
    input  logic [15:0]               wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [15:0]               rdata,
    output logic [2:0]                cc,
    mem_access_unit_if.master         mem
);

    state_e      state;
    state_e      state_next;
    op_e         op_q;
    logic [15:0] ea_q;
    logic [15:0] wdata_q;
    logic [15:0] ptr_q;
    logic        err_q;

    logic        in_acc;
    logic        expired;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;

    assign in_acc = (state == S_ACC1) || (state == S_ACC2);

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_acc || mem.ready),
        .tick    (in_acc && !mem.ready),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path through
        // the block leaves a signal unassigned and infers a latch.
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        unique case (state)
            S_IDLE: begin
                if (req)
                    state_next = S_ACC1;
            end
            S_ACC1: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_addr = ea_q;
                if (op_q == OP_ST) begin
                    mem_we    = 1'b1;
                    mem_wdata = wdata_q;
                end
                if (mem.ready)
                    state_next = is_indirect(op_q) ? S_ACC2 : S_FIN;
                else if (expired)
                    state_next = S_FIN;
            end
            S_ACC2: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_addr = ptr_q;
                if (op_q == OP_STI) begin
                    mem_we    = 1'b1;
                    mem_wdata = wdata_q;
                end
                if (mem.ready || expired)
                    state_next = S_FIN;
            end
            S_FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                err        = err_q;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign mem.en    = mem_en;
    assign mem.we    = mem_we;
    assign mem.addr  = mem_addr;
    assign mem.wdata = mem_wdata;

    // Request latches, pointer capture and load result; READY is only
    // consulted in the access states, where MEM_EN is always high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_LD;
            ea_q    <= '0;
            wdata_q <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            rdata   <= '0;
            cc      <= CC_RESET;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        op_q    <= op_e'(op);
                        ea_q    <= ea;
                        wdata_q <= wdata;
                        err_q   <= 1'b0;
                    end
                end
                S_ACC1: begin
                    if (mem.ready) begin
                        if (op_q == OP_LD) begin
                            rdata <= mem.rdata;
                            cc    <= cc_of(mem.rdata);
                        end else if (is_indirect(op_q)) begin
                            ptr_q <= mem.rdata;
                        end
                    end else if (expired) begin
                        err_q <= 1'b1;
                    end
                end
                S_ACC2: begin
                    if (mem.ready) begin
                        if (op_q == OP_LDI) begin
                            rdata <= mem.rdata;
                            cc    <= cc_of(mem.rdata);
                        end
                    end else if (expired) begin
                        err_q <= 1'b1;
                    end
                end
                S_FIN: err_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a transaction-level model predicts
// the per-cycle outputs, and a memory responder plays the ready-handshaked slave.
module tb_mem_access_unit;

    localparam int         WMAX   = 4;
    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_ST  = 2'b01;
    localparam logic [1:0] OP_LDI = 2'b10;
    localparam logic [1:0] OP_STI = 2'b11;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic        en;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic [2:0]  cc;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [1:0]  op;
    logic [15:0] ea;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rdata;
    logic [2:0]  cc;

    mem_access_unit_if mem_bus ();

    mem_access_unit #(
        .WAIT_MAX (WMAX),
        .CC_RESET (3'b010)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .op    (op),
        .ea    (ea),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .rdata (rdata),
        .cc    (cc),
        .mem   (mem_bus.master)
    );

    always #5 clk = ~clk;

    logic [15:0] mem_model [logic [15:0]];
    cyc_t        trace [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          cyc = 0;
    int          req_cyc = 0;
    int          done_cyc = -1;
    int          err_cyc = -1;
    int          cfg_d1 = 0;
    int          cfg_d2 = 0;
    logic [15:0] cur_rdata = 16'h0000;
    logic [2:0]  cur_cc = 3'b010;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rd(input logic [15:0] a);
        return mem_model.exists(a) ? mem_model[a] : 16'h0000;
    endfunction

    function automatic logic [2:0] nzp(input logic [15:0] v);
        if (v[15])       return 3'b100;
        if (v == 16'h0)  return 3'b010;
        return 3'b001;
    endfunction

    task automatic push(input cyc_t c);
        trace[wr_ptr] = c;
        wr_ptr++;
    endtask

    // One memory access: d wait cycles before READY (-1 = never), bounded by WMAX.
    task automatic add_access(input logic [15:0] a, input logic w, input logic [15:0] wd,
                              input int d, input logic [15:0] r, input logic [2:0] c,
                              output bit ok);
        int   n;
        cyc_t e;
        ok = (d >= 0) && (d < WMAX);
        n  = ok ? d + 1 : WMAX;
        e  = '{busy: 1'b1, done: 1'b0, err: 1'b0, en: 1'b1, we: w,
               addr: a, wdata: wd, rdata: r, cc: c};
        for (int i = 0; i < n; i++) push(e);
    endtask

    task automatic build_trace(input logic [1:0] o, input logic [15:0] a, input logic [15:0] wd,
                               input int d1, input int d2);
        logic [15:0] r;
        logic [15:0] nr;
        logic [2:0]  c;
        logic [2:0]  nc;
        logic [15:0] ptr;
        bit          ok;
        cyc_t        fin;
        r  = cur_rdata;
        c  = cur_cc;
        nr = r;
        nc = c;
        add_access(a, o == OP_ST, (o == OP_ST) ? wd : 16'h0, d1, r, c, ok);
        if (ok && (o == OP_LDI || o == OP_STI)) begin
            ptr = rd(a);
            add_access(ptr, o == OP_STI, (o == OP_STI) ? wd : 16'h0, d2, r, c, ok);
        end
        if (ok && o == OP_LD)  nr = rd(a);
        if (ok && o == OP_LDI) nr = rd(rd(a));
        if (ok && (o == OP_LD || o == OP_LDI)) nc = nzp(nr);
        fin = '{busy: 1'b1, done: 1'b1, err: !ok, en: 1'b0, we: 1'b0,
                addr: 16'h0, wdata: 16'h0, rdata: nr, cc: nc};
        push(fin);
    endtask

    task automatic start_txn(input logic [1:0] o, input logic [15:0] a, input logic [15:0] wd,
                             input int d1, input int d2, input bit hold);
        @(posedge clk);
        #2;
        build_trace(o, a, wd, d1, d2);
        cfg_d1  = d1;
        cfg_d2  = d2;
        req     = 1'b1;
        op      = o;
        ea      = a;
        wdata   = wd;
        req_cyc = cyc;
        @(posedge clk);
        #2;
        if (!hold) req = 1'b0;
    endtask

    task automatic wait_txn(input bit hold);
        int guard;
        guard = 0;
        while (rd_ptr != wr_ptr && guard < 200) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (hold) req = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [15:0] a, input logic [15:0] wd,
                       input int d1, input int d2, input bit hold);
        start_txn(o, a, wd, d1, d2, hold);
        wait_txn(hold);
    endtask

    initial begin
        cyc_t e;
        int   dly;
        int   wcnt;
        int   acc_idx;

        rst_n         = 1'b0;
        req           = 1'b0;
        op            = 2'b00;
        ea            = 16'h0;
        wdata         = 16'h0;
        mem_bus.ready = 1'b0;
        mem_bus.rdata = 16'hDEAD;
        wcnt          = 0;
        acc_idx       = 0;
        mem_model[16'h3000] = 16'h8001;
        mem_model[16'h3002] = 16'h5000;
        mem_model[16'h5000] = 16'h0000;
        mem_model[16'hFFFF] = 16'h0000;
        mem_model[16'h3004] = 16'h1234;

        fork
            // Compare process: every cycle, DUT outputs against the model trace.
            forever begin
                @(posedge clk);
                cyc++;
                #1;
                e = '0;
                if (!rst_n) begin
                    rd_ptr    = wr_ptr;
                    cur_rdata = 16'h0000;
                    cur_cc    = 3'b010;
                    e.rdata   = cur_rdata;
                    e.cc      = cur_cc;
                end else if (rd_ptr != wr_ptr) begin
                    e         = trace[rd_ptr];
                    rd_ptr++;
                    cur_rdata = e.rdata;
                    cur_cc    = e.cc;
                end else begin
                    e.rdata = cur_rdata;
                    e.cc    = cur_cc;
                end
                check($sformatf("cyc%0d busy", cyc), 32'(busy), 32'(e.busy));
                check($sformatf("cyc%0d done", cyc), 32'(done), 32'(e.done));
                check($sformatf("cyc%0d err", cyc), 32'(err), 32'(e.err));
                check($sformatf("cyc%0d mem_en", cyc), 32'(mem_bus.en), 32'(e.en));
                check($sformatf("cyc%0d rdata", cyc), 32'(rdata), 32'(e.rdata));
                check($sformatf("cyc%0d cc", cyc), 32'(cc), 32'(e.cc));
                if (e.en) begin
                    check($sformatf("cyc%0d mem_we", cyc), 32'(mem_bus.we), 32'(e.we));
                    check($sformatf("cyc%0d mem_addr", cyc), 32'(mem_bus.addr), 32'(e.addr));
                    check($sformatf("cyc%0d mem_wdata", cyc), 32'(mem_bus.wdata), 32'(e.wdata));
                end
                if (done) done_cyc = cyc;
                if (err)  err_cyc  = cyc;
            end

            // Memory responder: READY after the configured wait per access.
            forever begin
                @(negedge clk);
                if (!mem_bus.en) begin
                    mem_bus.ready = 1'b0;
                    mem_bus.rdata = 16'hDEAD;
                    wcnt          = 0;
                    acc_idx       = 0;
                end else begin
                    if (mem_bus.ready) begin
                        wcnt = 0;
                        acc_idx++;
                    end
                    dly = (acc_idx == 0) ? cfg_d1 : cfg_d2;
                    if (dly >= 0 && wcnt == dly) begin
                        mem_bus.ready = 1'b1;
                        mem_bus.rdata = rd(mem_bus.addr);
                        if (mem_bus.we) mem_model[mem_bus.addr] = mem_bus.wdata;
                    end else begin
                        mem_bus.ready = 1'b0;
                        mem_bus.rdata = 16'hDEAD;
                        wcnt++;
                    end
                end
            end

            // Directed stimulus with hand-computed expectations.
            begin
                repeat (3) @(posedge clk);
                #2;
                check("reset busy", 32'(busy), 32'h0);
                check("reset done", 32'(done), 32'h0);
                check("reset err", 32'(err), 32'h0);
                check("reset mem_en", 32'(mem_bus.en), 32'h0);
                check("reset mem_we", 32'(mem_bus.we), 32'h0);
                check("reset mem_addr", 32'(mem_bus.addr), 32'h0);
                check("reset mem_wdata", 32'(mem_bus.wdata), 32'h0);
                check("reset rdata", 32'(rdata), 32'h0);
                check("reset cc", 32'(cc), 32'h2);
                @(negedge clk);
                rst_n = 1'b1;

                run(OP_ST, 16'h4000, 16'h1234, 3, 0, 1'b0);
                check("st latency", 32'(done_cyc - req_cyc), 32'd5);
                check("st mem[4000]", 32'(rd(16'h4000)), 32'h1234);
                check("st rdata kept", 32'(rdata), 32'h0000);
                check("st cc kept", 32'(cc), 32'h2);

                run(OP_LD, 16'h3000, 16'h0, 0, 0, 1'b0);
                check("ld latency", 32'(done_cyc - req_cyc), 32'd2);
                check("ld rdata", 32'(rdata), 32'h8001);
                check("ld cc", 32'(cc), 32'h4);

                run(OP_LDI, 16'h3002, 16'h0, 0, 0, 1'b0);
                check("ldi latency", 32'(done_cyc - req_cyc), 32'd3);
                check("ldi rdata", 32'(rdata), 32'h0000);
                check("ldi cc", 32'(cc), 32'h2);

                run(OP_LD, 16'h3004, 16'h0, 1, 0, 1'b0);
                check("ld wait1 latency", 32'(done_cyc - req_cyc), 32'd3);
                check("ld wait1 rdata", 32'(rdata), 32'h1234);
                check("ld wait1 cc", 32'(cc), 32'h1);

                run(OP_STI, 16'hFFFF, 16'h7FFF, 0, 2, 1'b0);
                check("sti latency", 32'(done_cyc - req_cyc), 32'd5);
                check("sti mem[0000]", 32'(rd(16'h0000)), 32'h7FFF);
                check("sti rdata kept", 32'(rdata), 32'h1234);
                check("sti cc kept", 32'(cc), 32'h1);

                run(OP_LD, 16'h0000, 16'h0, WMAX - 1, 0, 1'b0);
                check("ld last-cycle latency", 32'(done_cyc - req_cyc), 32'd5);
                check("ld last-cycle rdata", 32'(rdata), 32'h7FFF);

                run(OP_LD, 16'h3000, 16'h0, -1, 0, 1'b1);
                check("timeout latency", 32'(done_cyc - req_cyc), 32'd5);
                check("timeout err with done", 32'(err_cyc), 32'(done_cyc));
                check("timeout rdata kept", 32'(rdata), 32'h7FFF);
                check("timeout cc kept", 32'(cc), 32'h1);

                start_txn(OP_LDI, 16'h3002, 16'h0, 0, -1, 1'b0);
                @(posedge clk);
                #3;
                check("pre-reset mem_addr", 32'(mem_bus.addr), 32'h5000);
                rst_n = 1'b0;
                #1;
                check("mid reset mem_en", 32'(mem_bus.en), 32'h0);
                check("mid reset busy", 32'(busy), 32'h0);
                check("mid reset done", 32'(done), 32'h0);
                check("mid reset cc", 32'(cc), 32'h2);
                check("mid reset rdata", 32'(rdata), 32'h0000);
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (2) @(posedge clk);

                run(OP_LD, 16'h3000, 16'h0, 0, 0, 1'b0);
                check("post-reset ld latency", 32'(done_cyc - req_cyc), 32'd2);
                check("post-reset ld rdata", 32'(rdata), 32'h8001);
                check("post-reset ld cc", 32'(cc), 32'h4);

                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
                $finish;
            end
        join
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Consumes the 16-bit effective address produced by the LC3 address datapath and performs the corresponding memory transaction for LD, ST, LDI and STI. It sequences one or two memory accesses over a ready-handshaked memory port and returns load data plus N/Z/P condition codes to the datapath. It sits between the EA adder output and the unified instruction/data memory.

Parameters:
WAIT_MAX, 16, max cycles an access may wait for MEM_READY before abort with ERR; 0 disables timeout
CC_RESET, 3'b010, reset value of CC (Z set)

Ports:
CLK  input  1  system clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
REQ  input  1  start request, sampled only in IDLE
OP  input  2  00 LD, 01 ST, 10 LDI, 11 STI
EA  input  16  effective address, latched with REQ
WDATA  input  16  store data, latched with REQ
BUSY  output  1  high whenever state != IDLE
DONE  output  1  one-cycle completion pulse
ERR  output  1  one-cycle pulse with DONE on timeout abort
RDATA  output  16  last load result
CC  output  3  {N,Z,P} of last load result
MEM_EN  output  1  memory access strobe
MEM_WE  output  1  write enable, valid with MEM_EN
MEM_ADDR  output  16  memory address
MEM_WDATA  output  16  memory write data
MEM_RDATA  input  16  memory read data, valid when MEM_READY
MEM_READY  input  1  access complete this cycle

Behaviour:
- Reset (async, RST_N=0): state IDLE; BUSY/DONE/ERR/MEM_EN/MEM_WE=0; MEM_ADDR/MEM_WDATA/RDATA=0; CC=CC_RESET; wait counter 0. Reset mid-access drops MEM_EN immediately; transaction discarded, no DONE.
- States: IDLE, ACC1, ACC2, FIN.
- IDLE: REQ=1 latches OP, EA, WDATA -> ACC1 next cycle. REQ in any other state ignored (not queued).
- ACC1: MEM_EN=1, MEM_ADDR=latched EA; MEM_WE=1 only for ST; MEM_WDATA=latched WDATA for ST else 0. On MEM_READY: LD -> RDATA<=MEM_RDATA, CC update, -> FIN; ST -> FIN; LDI/STI -> pointer<=MEM_RDATA, -> ACC2.
- ACC2: MEM_EN=1, MEM_ADDR=pointer; MEM_WE=1 only for STI. On MEM_READY: LDI -> RDATA, CC update; -> FIN.
- FIN: DONE=1 for exactly this cycle, MEM_EN=0; -> IDLE. REQ in FIN ignored.
- MEM_RDATA sampled only when MEM_EN and MEM_READY both high.
- Latency (READY in first access cycle): LD/ST DONE 2 cycles after REQ cycle; LDI/STI 3 cycles. Each wait cycle adds one.
- CC: N=RDATA[15]; Z=(RDATA==0); P=otherwise; exactly one bit set. Updated only on LD/LDI completion; ST/STI leave CC and RDATA unchanged.
- Timeout: counter clears on entering ACC1/ACC2, increments each cycle without READY; when it reaches WAIT_MAX with no READY -> FIN with ERR=1 alongside DONE; RDATA, CC unchanged; MEM_EN drops. READY in same cycle counter reaches WAIT_MAX counts as success.
- Pointer and address are 16-bit, no arithmetic; 16'hFFFF and 16'h0000 legal addresses.

Decomposition:
- Shared package lc3_mem_pkg: OP encodings (OP_LD, OP_ST, OP_LDI, OP_STI), state encodings, CC bit positions, CC_Z constant.
- One sub-module: mem_wait_timer (clear, tick, WAIT_MAX compare, expired output); FSM, latches and CC logic in top.

Test Plan:
- LD EA=16'h3000, memory returns 16'h8001 with READY in first ACC1 cycle -> MEM_ADDR=3000, MEM_WE=0; DONE 2 cycles after REQ; RDATA=8001, CC=100.
- ST EA=16'h4000, WDATA=16'h1234, READY delayed 3 cycles -> MEM_EN held 4 cycles, MEM_WE=1, MEM_WDATA=1234; DONE once; CC stays 010.
- LDI EA=16'h3002, mem[3002]=16'h5000, mem[5000]=16'h0000 -> second access MEM_ADDR=5000; RDATA=0000, CC=010; DONE 3 cycles after REQ.
- STI EA=16'hFFFF, mem[FFFF]=16'h0000, WDATA=16'h7FFF -> second access MEM_ADDR=0000, MEM_WE=1, MEM_WDATA=7FFF; RDATA/CC unchanged.
- WAIT_MAX=4, LD with READY never asserted -> MEM_EN high 4 cycles, then DONE=ERR=1 one cycle; RDATA/CC unchanged; REQ held high throughout ACC1 not re-accepted until IDLE.
- LDI with RST_N pulsed low during ACC2 -> MEM_EN=0 immediately, BUSY=0, CC=010, no DONE; new LD after release completes normally.
